alu4_issue: RTL

- Issue/retire stage wrapped around the 4-bit ALU datapath.
- Accepts one ALU request (3-bit op plus two 4-bit operands) over a valid/ready handshake, registers the operands and drives them to the function units.
- Drives the s2/s1/s0 select lines of the 4-bit 8-to-1 result mux, captures the mux output and derives zero/negative flags.
- Holds the result on a valid/ready output port until it is consumed, and keeps a saturating count of retired operations.

---
 rtl/alu4_issue.sv | 127 ++++++++++++
 1 files changed

// File: rtl/alu4_issue.sv
// Issue/retire stage for the 4-bit ALU: latches a request, drives selects/operands, captures the mux result.
// Latency: request accepted in T, result valid from T+2; a held result stalls new requests until res_ready.
`timescale 1ns/1ps
module alu4_issue #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [3:0]       req_a,
   input  logic [3:0]       req_b,
   output logic [3:0]       opnd_a,
   output logic [3:0]       opnd_b,
   output logic             mux_s2,
   output logic             mux_s1,
   output logic             mux_s0,
   input  logic [3:0]       mux_y,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [3:0]       res_y,
   output logic             res_z,
   output logic             res_n,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] ops_done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [2:0]       r_op;
   logic [3:0]       r_opnd_a;
   logic [3:0]       r_opnd_b;
   logic [3:0]       r_res_y;
   logic             r_res_z;
   logic             r_res_n;
   logic [CNT_W-1:0] r_ops_done;
   logic             w_req_hs;
   logic             w_res_hs;

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = 1'b0;
      res_valid   = 1'b0;
      case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) w_state_nxt = EXEC;
         end
         EXEC: begin
            w_state_nxt = DONE;
         end
         DONE: begin
            res_valid = 1'b1;
            // Retiring frees the slot in the same cycle, so a waiting request can follow back-to-back.
            req_ready = res_ready;
            if (res_ready) w_state_nxt = req_valid ? EXEC : IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign w_req_hs = req_valid & req_ready;
   assign w_res_hs = res_valid & res_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_op     <= 3'b000;
         r_opnd_a <= 4'h0;
         r_opnd_b <= 4'h0;
      end else if (w_req_hs) begin
         r_op     <= req_op;
         r_opnd_a <= req_a;
         r_opnd_b <= req_b;
      end
   end

   // Flags come from the captured value so they stay coherent with res_y while it is held.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_res_y <= 4'h0;
         r_res_z <= 1'b1;
         r_res_n <= 1'b0;
      end else if (r_state == EXEC) begin
         r_res_y <= mux_y;
         r_res_z <= (mux_y == 4'b0000);
         r_res_n <= mux_y[3];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ops_done <= '0;
      end else if (cnt_clr) begin
         r_ops_done <= '0;
      end else if (w_res_hs && (r_ops_done != {CNT_W{1'b1}})) begin
         r_ops_done <= r_ops_done + 1'b1;
      end
   end

   assign opnd_a   = r_opnd_a;
   assign opnd_b   = r_opnd_b;
   assign mux_s2   = r_op[2];
   assign mux_s1   = r_op[1];
   assign mux_s0   = r_op[0];
   assign res_y    = r_res_y;
   assign res_z    = r_res_z;
   assign res_n    = r_res_n;
   assign ops_done = r_ops_done;

endmodule
